// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit_if
//  Description : Bundles the instruction/memory handshake inputs and every
//                datapath control output of the multi-cycle control unit.
//                master = control unit, slave = datapath / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int ST_SIZE   = 4,
    parameter int WORD_SIZE = 16
);
    logic [3:0]           opcode;
    logic [5:0]           funct;
    logic                 bcond;
    logic                 i_mem_ready;
    logic                 d_mem_ready;
    logic [ST_SIZE-1:0]   current_state;
    logic                 IR_write;
    logic                 PVSWriteEn;
    logic                 pc_update;
    logic                 RegWrite;
    logic                 is_JL_type;
    logic                 reg_dst;
    logic [1:0]           mem_to_reg;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [2:0]           ALU_func;
    logic [1:0]           pc_src;
    logic                 i_readM;
    logic                 d_readM;
    logic                 d_writeM;
    logic                 output_port_en;
    logic                 is_halted;
    logic [WORD_SIZE-1:0] num_inst;

    modport master (
        input  opcode, funct, bcond, i_mem_ready, d_mem_ready,
        output current_state, IR_write, PVSWriteEn, pc_update, RegWrite,
               is_JL_type, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ALU_func, pc_src, i_readM, d_readM, d_writeM,
               output_port_en, is_halted, num_inst
    );

    modport slave (
        output opcode, funct, bcond, i_mem_ready, d_mem_ready,
        input  current_state, IR_write, PVSWriteEn, pc_update, RegWrite,
               is_JL_type, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ALU_func, pc_src, i_readM, d_readM, d_writeM,
               output_port_en, is_halted, num_inst
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : FSM sequencing the 16-bit multi-cycle datapath. Decodes the
//                IR opcode/funct, drives all write enables and mux selects,
//                handshakes with instruction/data memory, counts retired
//                instructions and holds the halt flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ST_SIZE   = 4,
    parameter int WORD_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    localparam logic [ST_SIZE-1:0] c_ST_IF   = ST_SIZE'(0);
    localparam logic [ST_SIZE-1:0] c_ST_ID   = ST_SIZE'(1);
    localparam logic [ST_SIZE-1:0] c_ST_EX1  = ST_SIZE'(2);
    localparam logic [ST_SIZE-1:0] c_ST_MEM1 = ST_SIZE'(3);
    localparam logic [ST_SIZE-1:0] c_ST_WB   = ST_SIZE'(4);
    localparam logic [ST_SIZE-1:0] c_ST_HALT = ST_SIZE'(5);

    localparam logic [3:0] c_OP_ALU = 4'd15;
    localparam logic [3:0] c_OP_ADI = 4'd4;
    localparam logic [3:0] c_OP_ORI = 4'd5;
    localparam logic [3:0] c_OP_LHI = 4'd6;
    localparam logic [3:0] c_OP_LWD = 4'd7;
    localparam logic [3:0] c_OP_SWD = 4'd8;
    localparam logic [3:0] c_OP_JMP = 4'd9;
    localparam logic [3:0] c_OP_JAL = 4'd10;

    localparam logic [5:0] c_FN_JPR = 6'd25;
    localparam logic [5:0] c_FN_JRL = 6'd26;
    localparam logic [5:0] c_FN_WWD = 6'd28;
    localparam logic [5:0] c_FN_HLT = 6'd29;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_ORR = 3'd3;

    logic [ST_SIZE-1:0]   state_q, state_d;
    logic [WORD_SIZE-1:0] num_inst_q;
    logic                 is_halted_q;

    logic op_alu, op_rarith, op_jpr, op_jrl, op_wwd, op_hlt;
    logic op_imm, op_lwd, op_swd, op_br, op_jmp, op_jal, needs_ex;

    logic       commit, halt_commit;
    logic       ir_write, pc_update, reg_write, is_jl, reg_dst, alu_src_a;
    logic       i_read, d_read, d_write, out_en;
    logic [1:0] mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_func;

    // Instruction class decode from the IR fields.
    assign op_alu    = (bus.opcode == c_OP_ALU);
    assign op_rarith = op_alu && (bus.funct[5:3] == 3'd0);
    assign op_jpr    = op_alu && (bus.funct == c_FN_JPR);
    assign op_jrl    = op_alu && (bus.funct == c_FN_JRL);
    assign op_wwd    = op_alu && (bus.funct == c_FN_WWD);
    assign op_hlt    = op_alu && (bus.funct == c_FN_HLT);
    assign op_imm    = (bus.opcode == c_OP_ADI) || (bus.opcode == c_OP_ORI) ||
                       (bus.opcode == c_OP_LHI);
    assign op_lwd    = (bus.opcode == c_OP_LWD);
    assign op_swd    = (bus.opcode == c_OP_SWD);
    assign op_br     = (bus.opcode[3:2] == 2'b00);
    assign op_jmp    = (bus.opcode == c_OP_JMP);
    assign op_jal    = (bus.opcode == c_OP_JAL);
    assign needs_ex  = op_rarith || op_imm || op_lwd || op_swd || op_br;

    // Next-state and control decode; everything stays quiet while reset is high.
    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        halt_commit = 1'b0;
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        reg_write   = 1'b0;
        is_jl       = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        i_read      = 1'b0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        out_en      = 1'b0;
        mem_to_reg  = 2'd0;
        alu_src_b   = 2'd0;
        pc_src      = 2'd0;
        alu_func    = c_ALU_ADD;
        if (!reset) begin
            case (state_q)
                c_ST_IF: begin
                    i_read = 1'b1;
                    if (bus.i_mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = c_ST_ID;
                    end
                end
                c_ST_ID: begin
                    if (needs_ex) begin
                        state_d = c_ST_EX1;
                    end else begin
                        // Jumps, links, WWD, HLT and undefined encodings retire here.
                        commit    = 1'b1;
                        pc_update = !op_hlt;
                        state_d   = op_hlt ? c_ST_HALT : c_ST_IF;
                        halt_commit = op_hlt;
                        if (op_jmp || op_jal) pc_src = 2'd2;
                        if (op_jpr || op_jrl) pc_src = 2'd3;
                        if (op_jal || op_jrl) begin
                            reg_write  = 1'b1;
                            is_jl      = 1'b1;
                            mem_to_reg = 2'd2;
                        end
                        out_en = op_wwd;
                    end
                end
                c_ST_EX1: begin
                    if (op_br) begin
                        alu_func  = c_ALU_SUB;
                        alu_src_b = bus.opcode[1] ? 2'd2 : 2'd0;
                        commit    = 1'b1;
                        pc_update = 1'b1;
                        pc_src    = bus.bcond ? 2'd1 : 2'd0;
                        state_d   = c_ST_IF;
                    end else if (op_rarith) begin
                        alu_func = bus.funct[2:0];
                        state_d  = c_ST_WB;
                    end else begin
                        // Immediate forms and address generation for loads/stores.
                        alu_src_b = 2'd1;
                        alu_src_a = (bus.opcode == c_OP_LHI);
                        alu_func  = (bus.opcode == c_OP_ORI) ? c_ALU_ORR : c_ALU_ADD;
                        state_d   = (op_lwd || op_swd) ? c_ST_MEM1 : c_ST_WB;
                    end
                end
                c_ST_MEM1: begin
                    if (op_lwd) begin
                        d_read = 1'b1;
                        if (bus.d_mem_ready) state_d = c_ST_WB;
                    end else if (op_swd) begin
                        d_write = 1'b1;
                        if (bus.d_mem_ready) begin
                            commit    = 1'b1;
                            pc_update = 1'b1;
                            state_d   = c_ST_IF;
                        end
                    end else begin
                        state_d = c_ST_IF;
                    end
                end
                c_ST_WB: begin
                    commit     = 1'b1;
                    reg_write  = 1'b1;
                    pc_update  = 1'b1;
                    reg_dst    = op_rarith;
                    mem_to_reg = op_lwd ? 2'd1 : 2'd0;
                    state_d    = c_ST_IF;
                end
                c_ST_HALT: state_d = c_ST_HALT;
                default:   state_d = c_ST_IF;
            endcase
        end
    end

    // State register, retired-instruction counter and halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_ST_IF;
            num_inst_q  <= '0;
            is_halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (commit) num_inst_q <= num_inst_q + 1'b1;
            if (halt_commit) is_halted_q <= 1'b1;
        end
    end

    assign bus.current_state  = state_q;
    assign bus.IR_write       = ir_write;
    assign bus.PVSWriteEn     = commit;
    assign bus.pc_update      = pc_update;
    assign bus.RegWrite       = reg_write;
    assign bus.is_JL_type     = is_jl;
    assign bus.reg_dst        = reg_dst;
    assign bus.mem_to_reg     = mem_to_reg;
    assign bus.alu_src_a      = alu_src_a;
    assign bus.alu_src_b      = alu_src_b;
    assign bus.ALU_func       = alu_func;
    assign bus.pc_src         = pc_src;
    assign bus.i_readM        = i_read;
    assign bus.d_readM        = d_read;
    assign bus.d_writeM       = d_write;
    assign bus.output_port_en = out_en;
    assign bus.is_halted      = is_halted_q;
    assign bus.num_inst       = num_inst_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit. Each
//                instruction's expected state walk and commit-cycle controls
//                come from a class-level reference model; memory latencies,
//                branch outcomes and spurious ready pulses are randomized.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ST_SIZE(4), .WORD_SIZE(16)) bus ();

    multicycle_control_unit #(.ST_SIZE(4), .WORD_SIZE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_count = 16'd0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Classes that pass through EX1 (arith, immediates, loads/stores, branches).
    function automatic bit goes_ex(input logic [3:0] op, input logic [5:0] fn);
        return (op == 4'd15 && fn < 6'd8) || (op >= 4'd4 && op <= 4'd8) || (op <= 4'd3);
    endfunction

    // Commit-cycle controls {RegWrite, pc_update, pc_src, reg_dst, mem_to_reg, is_JL, out_en}.
    function automatic logic [8:0] exp_commit(input logic [3:0] op, input logic [5:0] fn, input logic bc);
        logic rw, pu, rd, jl, oe;
        logic [1:0] ps, mtr;
        rw = 0; pu = 1; rd = 0; jl = 0; oe = 0; ps = 0; mtr = 0;
        if (op == 4'd15) begin
            if (fn < 6'd8) begin rw = 1; rd = 1; end
            else if (fn == 6'd25) ps = 3;
            else if (fn == 6'd26) begin ps = 3; rw = 1; jl = 1; mtr = 2; end
            else if (fn == 6'd28) oe = 1;
            else if (fn == 6'd29) pu = 0;
        end else if (op <= 4'd3) ps = bc ? 2'd1 : 2'd0;
        else if (op >= 4'd4 && op <= 4'd6) rw = 1;
        else if (op == 4'd7) begin rw = 1; mtr = 1; end
        else if (op == 4'd9) ps = 2;
        else if (op == 4'd10) begin ps = 2; rw = 1; jl = 1; mtr = 2; end
        return {rw, pu, ps, rd, mtr, jl, oe};
    endfunction

    // EX1 ALU controls {ALU_func, alu_src_a, alu_src_b}.
    function automatic logic [5:0] exp_alu(input logic [3:0] op, input logic [5:0] fn);
        if (op == 4'd15) return {fn[2:0], 1'b0, 2'd0};
        if (op == 4'd0 || op == 4'd1) return {3'd1, 1'b0, 2'd0};
        if (op == 4'd2 || op == 4'd3) return {3'd1, 1'b0, 2'd2};
        if (op == 4'd5) return {3'd3, 1'b0, 2'd1};
        if (op == 4'd6) return {3'd0, 1'b1, 2'd1};
        return {3'd0, 1'b0, 2'd1};
    endfunction

    // Runs one instruction from IF, with iw fetch-wait and mw data-wait cycles.
    task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input int iw,
                             input int mw, input logic bc);
        int path[$];
        int mem_done;
        int last;
        int st;
        path = {};
        repeat (iw + 1) path.push_back(0);
        path.push_back(1);
        if (goes_ex(op, fn)) begin
            path.push_back(2);
            if (op == 4'd7 || op == 4'd8) repeat (mw + 1) path.push_back(3);
            if (op != 4'd8 && op > 4'd3) path.push_back(4);
        end
        last = path.size() - 1;
        mem_done = -1;
        foreach (path[i]) if (path[i] == 3) mem_done = i;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            st = path[k];
            bus.i_mem_ready = (st == 0) ? (k == iw) : 1'($urandom_range(0, 1));
            bus.d_mem_ready = (st == 3) ? (k == mem_done) : 1'($urandom_range(0, 1));
            bus.bcond       = (st == 2) ? bc : 1'($urandom_range(0, 1));
            if (k == iw + 1) begin
                bus.opcode = op;
                bus.funct  = fn;
            end
            #1;
            if (k == 0) begin
                check_value("num_inst", 32'(bus.num_inst), 32'(exp_count));
                check_value("is_halted", 32'(bus.is_halted), 32'd0);
            end
            check_value($sformatf("state op%0d fn%0d k%0d", op, fn, k), 32'(bus.current_state), 32'(st));
            check_value($sformatf("strobes op%0d k%0d", op, k),
                        32'({bus.PVSWriteEn, bus.IR_write, bus.i_readM, bus.d_readM, bus.d_writeM}),
                        32'({k == last, st == 0 && k == iw, st == 0,
                             st == 3 && op == 4'd7, st == 3 && op == 4'd8}));
            if (k == last)
                check_value($sformatf("commit op%0d fn%0d", op, fn),
                            32'({bus.RegWrite, bus.pc_update, bus.pc_src, bus.reg_dst,
                                 bus.mem_to_reg, bus.is_JL_type, bus.output_port_en}),
                            32'(exp_commit(op, fn, bc)));
            else
                check_value($sformatf("quiet op%0d k%0d", op, k),
                            32'({bus.RegWrite, bus.pc_update, bus.output_port_en, bus.is_JL_type}), 32'd0);
            if (st == 2)
                check_value($sformatf("alu op%0d fn%0d", op, fn),
                            32'({bus.ALU_func, bus.alu_src_a, bus.alu_src_b}), 32'(exp_alu(op, fn)));
        end
        exp_count = exp_count + 16'd1;
    endtask

    int fn_list[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28, 8, 27, 63};

    initial begin
        logic [3:0] op;
        logic [5:0] fn;
        reset = 1'b1;
        bus.opcode = 4'd0; bus.funct = 6'd0; bus.bcond = 1'b0;
        bus.i_mem_ready = 1'b1; bus.d_mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_value("reset strobes",
                    32'({bus.IR_write, bus.PVSWriteEn, bus.pc_update, bus.RegWrite,
                         bus.i_readM, bus.d_readM, bus.d_writeM, bus.output_port_en}), 32'd0);
        check_value("reset state", 32'(bus.current_state), 32'd0);
        check_value("reset num_inst", 32'(bus.num_inst), 32'd0);
        check_value("reset halted", 32'(bus.is_halted), 32'd0);
        bus.i_mem_ready = 1'b0;
        reset = 1'b0;

        // Directed: ADD 0xF6C0, LWD with 3 wait cycles, BEQ taken/not taken, JAL 0xA123.
        run_instr(4'd15, 6'd0, 0, 0, 1'b0);
        run_instr(4'd7, 6'd0, 0, 3, 1'b0);
        run_instr(4'd1, 6'd0, 0, 0, 1'b1);
        run_instr(4'd1, 6'd0, 1, 0, 1'b0);
        run_instr(4'd10, 6'h23, 0, 0, 1'b0);

        // Randomized instruction mix (HLT excluded here).
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            fn = (op == 4'd15) ? 6'(fn_list[$urandom_range(0, 13)]) : 6'($urandom_range(0, 63));
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset during SWD data-memory wait abandons the store.
        @(negedge clk); bus.i_mem_ready = 1'b1; bus.d_mem_ready = 1'b0; #1;
        check_value("swd IF", 32'(bus.current_state), 32'd0);
        @(negedge clk); bus.i_mem_ready = 1'b0; bus.opcode = 4'd8; bus.funct = 6'd0; #1;
        check_value("swd ID", 32'(bus.current_state), 32'd1);
        @(negedge clk); #1;
        check_value("swd EX1", 32'(bus.current_state), 32'd2);
        @(negedge clk); #1;
        check_value("swd MEM1 write", 32'({bus.current_state, bus.d_writeM}), 32'({4'd3, 1'b1}));
        @(negedge clk); reset = 1'b1; bus.i_mem_ready = 1'b1; #1;
        check_value("swd reset strobes",
                    32'({bus.d_writeM, bus.PVSWriteEn, bus.i_readM, bus.IR_write}), 32'd0);
        @(negedge clk); reset = 1'b0; bus.i_mem_ready = 1'b0; #1;
        check_value("post-reset state", 32'(bus.current_state), 32'd0);
        check_value("post-reset num_inst", 32'(bus.num_inst), 32'd0);
        exp_count = 16'd0;

        run_instr(4'd4, 6'd0, 0, 0, 1'b0);

        // HLT 0xF01D then 20 cycles parked in HALT.
        run_instr(4'd15, 6'd29, 1, 0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.i_mem_ready = 1'($urandom_range(0, 1));
            bus.d_mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_value($sformatf("halt c%0d", c),
                        32'({bus.is_halted, bus.current_state, bus.i_readM, bus.PVSWriteEn,
                             bus.IR_write, bus.pc_update, bus.RegWrite, bus.num_inst}),
                        32'({1'b1, 4'd5, 5'd0, exp_count}));
        end

        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check_value("unhalt", 32'({bus.is_halted, bus.current_state, bus.num_inst}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the 16-bit multi-cycle datapath: ALU, instruction register, immediate generator, GPR file, PC, buffers and operand muxes.
- Decodes opcode/funct from the instruction register and drives every datapath write enable and mux select.
- Handshakes with instruction and data memory.
- Counts retired instructions and holds the halt status.

Parameters:
- ST_SIZE, 4, width of the state code.
- WORD_SIZE, 16, datapath word width; sets the num_inst width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  instruction register opcode field.
- funct  in  6  instruction register funct field.
- bcond  in  1  branch-condition result from the datapath comparator, valid in EX1.
- i_mem_ready  in  1  instruction memory has read data valid this cycle.
- d_mem_ready  in  1  data memory read/write completes this cycle.
- current_state  out  ST_SIZE  state code; drives the ALU-out buffer latch enable.
- IR_write  out  1  load the instruction register.
- PVSWriteEn  out  1  commit strobe, one cycle per instruction.
- pc_update  out  1  PC write request, gated by PVSWriteEn.
- RegWrite  out  1  GPR write request, gated by PVSWriteEn.
- is_JL_type  out  1  force the write destination to r2.
- reg_dst  out  1  write-register select: 0=rt, 1=rd.
- mem_to_reg  out  2  write-data select: 0=ALU-out buffer, 1=memory-data buffer, 2=PC+1.
- alu_src_a  out  1  ALU A select: 0=rs data, 1=zero.
- alu_src_b  out  2  ALU B select: 0=rt data, 1=imm_16, 2=zero.
- ALU_func  out  3  ALU operation: ADD=0, SUB=1, AND=2, ORR=3, NOT=4, TCP=5, SHL=6, SHR=7.
- pc_src  out  2  next-PC select: 0=PC+1, 1=PC+imm_16 (branch), 2=imm_16 (jump), 3=rs data.
- i_readM  out  1  instruction fetch request.
- d_readM  out  1  data memory read request.
- d_writeM  out  1  data memory write request.
- output_port_en  out  1  WWD output-port strobe.
- is_halted  out  1  HLT retired.
- num_inst  out  WORD_SIZE  count of retired instructions.

Behaviour:

State codes:
- IF=0, ID=1, EX1=2, MEM1=3, WB=4, HALT=5.
- Unused codes go to IF.

Reset:
- When reset=1 at a rising edge: state becomes IF, num_inst becomes 0, is_halted becomes 0.
- While reset=1, all strobe outputs (IR_write, PVSWriteEn, pc_update, RegWrite, i_readM, d_readM, d_writeM, output_port_en) are 0.
- Mux selects are 0 during reset and whenever unused.
- Reset mid-instruction abandons the instruction with no commit; the next fetch starts the cycle after reset deasserts.

IF state:
- i_readM=1.
- Stay in IF while i_mem_ready=0.
- When i_mem_ready=1: IR_write=1 that cycle, next state is ID.

Opcodes:
- ALU=15: funct 0-7 arithmetic, 25 JPR, 26 JRL, 28 WWD, 29 HLT.
- ADI=4, ORI=5, LHI=6, LWD=7, SWD=8.
- BNE=0, BEQ=1, BGZ=2, BLZ=3.
- JMP=9, JAL=10.

Per-class sequences (commit = PVSWriteEn=1 for exactly that one cycle):
- R-arith (funct 0-7): IF, ID, EX1, WB.
  - EX1: ALU_func=funct[2:0], alu_src_a=0, alu_src_b=0.
  - WB: commit, RegWrite=1, reg_dst=1, mem_to_reg=0, pc_update=1, pc_src=0.
- ADI / ORI / LHI: IF, ID, EX1, WB.
  - EX1: alu_src_b=1; ADD for ADI, ORR for ORI; LHI uses ADD with alu_src_a=1.
  - WB: as R-arith but reg_dst=0.
- LWD: IF, ID, EX1, MEM1, WB.
  - EX1: ADD with alu_src_b=1.
  - MEM1: d_readM=1; wait until d_mem_ready=1.
  - WB: commit, mem_to_reg=1, reg_dst=0, RegWrite=1, pc_update=1.
- SWD: IF, ID, EX1, MEM1.
  - MEM1: d_writeM=1; wait until d_mem_ready=1.
  - Commit with pc_update=1 in the d_mem_ready cycle; RegWrite=0; next state IF.
- Branches: IF, ID, EX1.
  - EX1: ALU_func=SUB; alu_src_b=0 for BNE/BEQ, alu_src_b=2 for BGZ/BLZ.
  - Commit in EX1 with pc_update=1 and pc_src = bcond ? 1 : 0.
- JMP / JAL: commit in ID, pc_update=1, pc_src=2.
  - JAL additionally: RegWrite=1, is_JL_type=1, mem_to_reg=2.
- JPR / JRL: commit in ID, pc_src=3.
  - JRL additionally: link as for JAL.
- WWD: commit in ID, output_port_en=1, pc_update=1, pc_src=0.
- HLT: commit in ID with pc_update=0; next state HALT.
  - HALT: is_halted=1, all strobes 0; stays in HALT until reset.
- Undefined opcode or funct: commit in ID as a NOP (pc_update=1, pc_src=0).

Commit rules:
- After every commit the next state is IF, except after HLT (next state HALT).
- num_inst increments by 1 on each commit cycle, HLT included.
- num_inst wraps from 0xFFFF to 0x0000.

Memory handshakes:
- A request is held asserted until its ready signal is seen.
- A ready signal arriving while no request is asserted is ignored.

Test Plan:
- ADD r1,r2,r3 (0xF6C0) with i_mem_ready=1 -> states 0,1,2,4; ALU_func=0 in EX1; commit in WB with RegWrite=1, reg_dst=1; num_inst=1.
- LWD with d_mem_ready held 0 for 3 cycles -> MEM1 for 4 cycles with d_readM=1; WB writes mem_to_reg=1; 5 cycles plus 3 wait cycles total.
- BEQ with bcond=1, then again with bcond=0 -> commit in EX1 with pc_src=1, then pc_src=0; RegWrite=0 both times.
- JAL 0xA123 -> commit in ID with pc_src=2, is_JL_type=1, mem_to_reg=2, RegWrite=1; 2-cycle instruction.
- HLT (0xF01D) -> is_halted=1 from the next cycle and held for 20 cycles; no i_readM; num_inst increments once.
- Reset asserted during a SWD MEM1 wait -> d_writeM drops to 0; state=IF and num_inst=0 after the edge; no commit occurs.
